// File: rtl/bus_dma_copy.sv
// bus_dma_copy: memory-to-memory word copy engine on the simple system bus.
//
// Software programs SRC, DST and LEN through the device register port and
// writes CTRL.START. The engine then copies LEN words, one read followed by one
// write per word, on its host port using the req/gnt/rvalid protocol. Only one
// transaction is ever outstanding. A level interrupt (DONE & IRQ_EN) signals
// completion.
//
// Register map (word offsets, decoded from dev_addr_i[4:2]):
//   0x00 SRC    RW
//   0x04 DST    RW
//   0x08 LEN    RW, LenWidth bits, upper bits read 0
//   0x0C CTRL   bit0 START (W, reads 0), bit1 IRQ_EN (RW), bit2 BUSY (RO),
//               bit3 DONE (RW1C), bit4 ERR (RW1C)
//   0x10 REMAIN RO
//   other       rdata 0, dev_err_o 1, writes ignored
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   dev_req_i .. dev_err_o  register port; response exactly one cycle after req
//   host_req_o .. host_err_i bus initiator port (host_be_o is always 4'hF)
//   irq_o                   completion interrupt (level)
module bus_dma_copy #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LenWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic                    dev_we_i,
  input  logic [3:0]              dev_be_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    host_req_o,
  input  logic                    host_gnt_i,
  output logic [AddressWidth-1:0] host_addr_o,
  output logic                    host_we_o,
  output logic [3:0]              host_be_o,
  output logic [DataWidth-1:0]    host_wdata_o,
  input  logic                    host_rvalid_i,
  input  logic [DataWidth-1:0]    host_rdata_i,
  input  logic                    host_err_i,
  output logic                    irq_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] src_q, src_d;
  logic [AddressWidth-1:0] dst_q, dst_d;
  logic [LenWidth-1:0]     len_q, len_d;
  logic                    irq_en_q, irq_en_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [AddressWidth-1:0] src_ptr_q, src_ptr_d;
  logic [AddressWidth-1:0] dst_ptr_q, dst_ptr_d;
  logic [LenWidth-1:0]     remain_q, remain_d;
  logic [DataWidth-1:0]    buf_q, buf_d;
  logic                    dev_rvalid_q, dev_rvalid_d;
  logic [DataWidth-1:0]    dev_rdata_q, dev_rdata_d;
  logic                    dev_err_q, dev_err_d;

  logic [2:0] reg_sel;
  logic       reg_wr;
  logic       reg_rd;
  logic       busy;
  logic       start;
  logic       unused_addr;

  assign reg_sel     = dev_addr_i[4:2];
  assign reg_wr      = dev_req_i & dev_we_i;
  assign reg_rd      = dev_req_i & ~dev_we_i;
  assign busy        = (state_q != S_IDLE);
  // START needs byte lane 0 enabled and is only honoured while idle.
  assign start       = reg_wr && (reg_sel == 3'd3) && dev_be_i[0] && dev_wdata_i[0] && !busy;
  assign unused_addr = ^{dev_addr_i[AddressWidth-1:5], dev_addr_i[1:0]};

  function automatic logic [DataWidth-1:0] be_merge(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [3:0]           be);
    logic [DataWidth-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    err_d        = err_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remain_d     = remain_q;
    buf_d        = buf_q;
    dev_rvalid_d = dev_req_i;
    dev_rdata_d  = '0;
    dev_err_d    = dev_req_i && (reg_sel > 3'd4);

    // Register reads
    if (reg_rd) begin
      case (reg_sel)
        3'd0:    dev_rdata_d = DataWidth'(src_q);
        3'd1:    dev_rdata_d = DataWidth'(dst_q);
        3'd2:    dev_rdata_d = DataWidth'(len_q);
        3'd3:    dev_rdata_d = DataWidth'({err_q, done_q, busy, irq_en_q, 1'b0});
        3'd4:    dev_rdata_d = DataWidth'(remain_q);
        default: dev_rdata_d = '0;
      endcase
    end

    // Register writes; the transfer setup registers are frozen while busy.
    if (reg_wr) begin
      case (reg_sel)
        3'd0: if (!busy) src_d = AddressWidth'(be_merge(DataWidth'(src_q), dev_wdata_i, dev_be_i));
        3'd1: if (!busy) dst_d = AddressWidth'(be_merge(DataWidth'(dst_q), dev_wdata_i, dev_be_i));
        3'd2: if (!busy) len_d = LenWidth'(be_merge(DataWidth'(len_q), dev_wdata_i, dev_be_i));
        3'd3: begin
          if (dev_be_i[0]) begin
            irq_en_d = dev_wdata_i[1];
            if (dev_wdata_i[3]) done_d = 1'b0;
            if (dev_wdata_i[4]) err_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (start) begin
      src_ptr_d = {src_q[AddressWidth-1:2], 2'b00};
      dst_ptr_d = {dst_q[AddressWidth-1:2], 2'b00};
      remain_d  = len_q;
      err_d     = 1'b0;
      if (len_q == '0) begin
        done_d = 1'b1;
      end else begin
        done_d  = 1'b0;
        state_d = S_RD_REQ;
      end
    end

    // Transfer FSM; placed after the W1C handling so a completion set wins.
    case (state_q)
      S_RD_REQ: if (host_gnt_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            buf_d   = host_rdata_i;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: if (host_gnt_i) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (host_rvalid_i) begin
          if (host_err_i) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            src_ptr_d = src_ptr_q + AddressWidth'(4);
            dst_ptr_d = dst_ptr_q + AddressWidth'(4);
            if (remain_q != '0) remain_d = remain_q - LenWidth'(1);
            if (remain_q <= LenWidth'(1)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remain_q     <= '0;
      dev_rvalid_q <= 1'b0;
      dev_rdata_q  <= '0;
      dev_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      err_q        <= err_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remain_q     <= remain_d;
      dev_rvalid_q <= dev_rvalid_d;
      dev_rdata_q  <= dev_rdata_d;
      dev_err_q    <= dev_err_d;
    end
  end

  // Data buffer is only observed in WR_REQ, so it needs no reset.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  // Host outputs decode straight from the state register, so they hold steady
  // for as long as the grant is withheld and drop on the reset edge.
  always_comb begin
    host_req_o   = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    host_we_o    = (state_q == S_WR_REQ);
    host_be_o    = 4'hF;
    host_addr_o  = '0;
    host_wdata_o = '0;
    if (state_q == S_RD_REQ) host_addr_o = src_ptr_q;
    if (state_q == S_WR_REQ) begin
      host_addr_o  = dst_ptr_q;
      host_wdata_o = buf_q;
    end
  end

  assign dev_rvalid_o = dev_rvalid_q;
  assign dev_rdata_o  = dev_rdata_q;
  assign dev_err_o    = dev_err_q;
  assign irq_o        = done_q & irq_en_q;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Self-checking bench for bus_dma_copy: a behavioural bus memory with a
// programmable grant delay and error injection, plus a word-level copy model.
module tb_bus_dma_copy;

  localparam logic [31:0] R_SRC = 32'h00, R_DST = 32'h04, R_LEN = 32'h08,
                          R_CTRL = 32'h0C, R_REM = 32'h10, R_BAD = 32'h14;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        dev_req_i, dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_addr_i, dev_wdata_i;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i, host_we_o, host_rvalid_i, host_err_i;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;
  logic        irq_o;

  always #5 clk = ~clk;

  bus_dma_copy dut (
    .clk_i(clk), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .irq_o(irq_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Behavioural bus memory
  logic [31:0] mem [logic [31:0]];
  int          gnt_delay    = 0;
  int          err_read_idx = 0;
  int          read_cnt     = 0;
  int          req_cycles   = 0;
  int          stab_viol    = 0;
  logic [31:0] rd_addrs[$];
  logic        we_seq[$];
  logic [31:0] exp_words[$];

  logic        resp_pending = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  int          waited = 0;
  logic [31:0] l_addr, l_wdata;
  logic        l_we;

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin
    host_gnt_i = 0; host_rvalid_i = 0; host_rdata_i = 0; host_err_i = 0;
    forever begin
      @(negedge clk);
      host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = 0;
      if (resp_pending) begin
        if (host_req_o) stab_viol++;  // a second request while one is outstanding
        host_rvalid_i = 1; host_rdata_i = resp_data; host_err_i = resp_err;
        resp_pending = 0;
      end else if (!host_req_o) begin
        waited = 0;
      end else begin
        req_cycles++;
        if (host_be_o !== 4'hF) stab_viol++;
        if (waited > 0 && (host_addr_o !== l_addr || host_we_o !== l_we || host_wdata_o !== l_wdata))
          stab_viol++;
        l_addr = host_addr_o; l_we = host_we_o; l_wdata = host_wdata_o;
        if (waited >= gnt_delay) begin
          host_gnt_i = 1;
          waited = 0;
          we_seq.push_back(host_we_o);
          resp_err = 0;
          resp_data = 0;
          if (host_we_o) begin
            mem[host_addr_o] = host_wdata_o;
          end else begin
            read_cnt++;
            rd_addrs.push_back(host_addr_o);
            resp_data = rdmem(host_addr_o);
            resp_err  = (read_cnt == err_read_idx);
          end
          resp_pending = 1;
        end else begin
          waited++;
        end
      end
    end
  end

  // Register port accesses: called at a negedge, return at the next negedge
  // (the response cycle).
  task automatic reg_wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be,
                        output logic err);
    dev_req_i = 1; dev_we_i = 1; dev_addr_i = off; dev_be_i = be; dev_wdata_i = data;
    @(negedge clk);
    dev_req_i = 0; dev_we_i = 0;
    check_eq("wr_rvalid", {31'b0, dev_rvalid_o}, 32'd1);
    err = dev_err_o;
  endtask

  task automatic reg_rd(input logic [31:0] off, output logic [31:0] data, output logic err);
    dev_req_i = 1; dev_we_i = 0; dev_addr_i = off; dev_be_i = 4'hF; dev_wdata_i = 0;
    @(negedge clk);
    dev_req_i = 0;
    check_eq("rd_rvalid", {31'b0, dev_rvalid_o}, 32'd1);
    data = dev_rdata_o; err = dev_err_o;
  endtask

  task automatic prog(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                      input logic [31:0] ctrl);
    logic e;
    reg_wr(R_SRC, src, 4'hF, e);
    reg_wr(R_DST, dst, 4'hF, e);
    reg_wr(R_LEN, len, 4'hF, e);
    reg_wr(R_CTRL, ctrl, 4'hF, e);
  endtask

  // Reference model: fill the source window and record what each destination
  // word must hold afterwards (word addresses wrap modulo 2^32).
  task automatic prep_src(input logic [31:0] src, input int len);
    logic [31:0] base;
    base = src & 32'hFFFF_FFFC;
    exp_words.delete();
    for (int i = 0; i < len; i++) begin
      mem[base + 32'(4 * i)] = $urandom;
      exp_words.push_back(mem[base + 32'(4 * i)]);
    end
  endtask

  task automatic check_copy(input string tag, input logic [31:0] dst);
    logic [31:0] base;
    base = dst & 32'hFFFF_FFFC;
    foreach (exp_words[i]) check_eq(tag, rdmem(base + 32'(4 * i)), exp_words[i]);
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    logic e;
    int n;
    n = 0;
    do begin
      reg_rd(R_CTRL, v, e);
      n++;
    end while (v[2] && n < 3000);
    check_eq("wait_idle_busy", {31'b0, v[2]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, s, d;
    logic        e;
    int          cnt, len, snap;
    logic [31:0] remain_seq[$];

    rst_i = 1; dev_req_i = 0; dev_we_i = 0; dev_be_i = 0; dev_addr_i = 0; dev_wdata_i = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_host_req", {31'b0, host_req_o}, 0);
    check_eq("rst_host_we", {31'b0, host_we_o}, 0);
    check_eq("rst_host_addr", host_addr_o, 0);
    check_eq("rst_host_wdata", host_wdata_o, 0);
    check_eq("rst_host_be", {28'b0, host_be_o}, 32'hF);
    check_eq("rst_dev_rvalid", {31'b0, dev_rvalid_o}, 0);
    check_eq("rst_dev_rdata", dev_rdata_o, 0);
    check_eq("rst_dev_err", {31'b0, dev_err_o}, 0);
    check_eq("rst_irq", {31'b0, irq_o}, 0);
    rst_i = 0;
    reg_rd(R_CTRL, v, e);  check_eq("rst_ctrl", v, 0);
    reg_rd(R_REM, v, e);   check_eq("rst_remain", v, 0);

    // Byte-enable merge on a register write
    reg_wr(R_SRC, 32'h1122_3344, 4'hF, e);
    reg_wr(R_SRC, 32'hAABB_CCDD, 4'b0101, e);
    reg_rd(R_SRC, v, e);   check_eq("be_merge_src", v, 32'h11BB_33DD);
    reg_wr(R_LEN, 32'hFFFF_FFFF, 4'hF, e);
    reg_rd(R_LEN, v, e);   check_eq("len_width", v, 32'h0000_FFFF);

    // 3-word copy with zero-latency grant
    gnt_delay = 0;
    prep_src(32'h0010_0000, 3);
    reg_wr(R_SRC, 32'h0010_0000, 4'hF, e);
    reg_wr(R_DST, 32'h0010_0100, 4'hF, e);
    reg_wr(R_LEN, 3, 4'hF, e);
    req_cycles = 0; we_seq.delete();
    reg_wr(R_CTRL, 32'h3, 4'hF, e);
    check_eq("w3_req_after_start", {31'b0, host_req_o}, 1);
    cnt = 1;
    while (!irq_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("w3_cycles_to_irq", cnt, 13);
    check_eq("w3_req_cycles", req_cycles, 6);
    v = 0;
    foreach (we_seq[i]) v = {v[30:0], we_seq[i]};
    check_eq("w3_we_pattern", v, 32'b010101);
    check_copy("w3_data", 32'h0010_0100);
    reg_rd(R_CTRL, v, e);  check_eq("w3_ctrl", v, 32'h0A);
    reg_rd(R_REM, v, e);   check_eq("w3_remain", v, 0);
    check_eq("w3_irq", {31'b0, irq_o}, 1);
    reg_wr(R_CTRL, 32'h0A, 4'hF, e);
    check_eq("w3_irq_w1c", {31'b0, irq_o}, 0);
    reg_rd(R_CTRL, v, e);  check_eq("w3_ctrl_after_w1c", v, 32'h02);

    // LEN = 0
    req_cycles = 0;
    prog(32'h100, 32'h200, 0, 32'h1);
    reg_rd(R_CTRL, v, e);  check_eq("len0_ctrl", v, 32'h08);
    repeat (10) @(negedge clk);
    check_eq("len0_no_req", req_cycles, 0);

    // Back-pressure: grant withheld 5 cycles on every request
    gnt_delay = 5; stab_viol = 0;
    prep_src(32'h2000, 4);
    prog(32'h2000, 32'h3000, 4, 32'h1);
    remain_seq.delete();
    cnt = 0;
    do begin
      reg_rd(R_REM, v, e);
      if (remain_seq.size() == 0 || remain_seq[$] != v) remain_seq.push_back(v);
      cnt++;
    end while (v != 0 && cnt < 1000);
    check_eq("bp_remain_steps", remain_seq.size(), 5);
    foreach (remain_seq[i]) check_eq("bp_remain_seq", remain_seq[i], 32'(4 - i));
    wait_idle();
    check_eq("bp_stability", stab_viol, 0);
    check_copy("bp_data", 32'h3000);

    // Bus error on the second read
    gnt_delay = 0; read_cnt = 0; err_read_idx = 2;
    prep_src(32'h4000, 4);
    for (int i = 0; i < 4; i++) mem[32'h5000 + 32'(4 * i)] = 0;
    prog(32'h4000, 32'h5000, 4, 32'h1);
    wait_idle();
    err_read_idx = 0;
    reg_rd(R_CTRL, v, e);  check_eq("err_ctrl", v, 32'h18);
    reg_rd(R_REM, v, e);   check_eq("err_remain", v, 3);
    snap = req_cycles;
    repeat (20) @(negedge clk);
    check_eq("err_no_more_req", req_cycles, snap);
    check_eq("err_word0", rdmem(32'h5000), exp_words[0]);
    check_eq("err_word1_untouched", rdmem(32'h5004), 0);
    reg_wr(R_CTRL, 32'h18, 4'hF, e);
    reg_rd(R_CTRL, v, e);  check_eq("err_w1c", v, 0);

    // Programming while busy
    gnt_delay = 4; we_seq.delete();
    prep_src(32'h6000, 3);
    prog(32'h6000, 32'h7000, 3, 32'h1);
    reg_wr(R_SRC, 32'h9000, 4'hF, e);   check_eq("busy_src_wr_err", {31'b0, e}, 0);
    reg_wr(R_CTRL, 32'h1, 4'hF, e);     check_eq("busy_start_err", {31'b0, e}, 0);
    reg_rd(R_SRC, v, e);                check_eq("busy_src_kept", v, 32'h6000);
    reg_rd(R_BAD, v, e);
    check_eq("bad_off_err", {31'b0, e}, 1);
    check_eq("bad_off_rdata", v, 0);
    wait_idle();
    check_copy("busy_data", 32'h7000);
    check_eq("busy_txn_count", we_seq.size(), 6);
    reg_rd(R_REM, v, e);   check_eq("busy_remain", v, 0);

    // Address wrap
    gnt_delay = 0; rd_addrs.delete();
    prep_src(32'hFFFF_FFFC, 2);
    prog(32'hFFFF_FFFC, 32'h800, 2, 32'h1);
    wait_idle();
    check_eq("wrap_rd0", rd_addrs[0], 32'hFFFF_FFFC);
    check_eq("wrap_rd1", rd_addrs[1], 32'h0);
    check_copy("wrap_data", 32'h800);

    // Reset mid-copy
    gnt_delay = 3;
    prep_src(32'hA000, 5);
    prog(32'hA000, 32'hB000, 5, 32'h3);
    repeat (7) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    check_eq("rstmid_req", {31'b0, host_req_o}, 0);
    snap = req_cycles;
    repeat (10) @(negedge clk);
    check_eq("rstmid_no_req", req_cycles, snap);
    reg_rd(R_SRC, v, e);   check_eq("rstmid_src", v, 0);
    reg_rd(R_DST, v, e);   check_eq("rstmid_dst", v, 0);
    reg_rd(R_LEN, v, e);   check_eq("rstmid_len", v, 0);
    reg_rd(R_CTRL, v, e);  check_eq("rstmid_ctrl", v, 0);
    reg_rd(R_REM, v, e);   check_eq("rstmid_remain", v, 0);
    check_eq("rstmid_irq", {31'b0, irq_o}, 0);

    // Randomized copies, including unaligned programmed addresses
    for (int it = 0; it < 5; it++) begin
      len = $urandom_range(1, 8);
      gnt_delay = $urandom_range(0, 3);
      s = 32'h0001_0000 + 32'(it * 32'h1000) + 32'($urandom_range(0, 63));
      d = 32'h0002_0000 + 32'(it * 32'h1000) + 32'($urandom_range(0, 63));
      v = {30'b0, 1'($urandom_range(0, 1)), 1'b1};
      prep_src(s, len);
      prog(s, d, 32'(len), v);
      wait_idle();
      check_copy("rnd_data", d);
      reg_rd(R_REM, v, e);   check_eq("rnd_remain", v, 0);
      reg_rd(R_SRC, v, e);   check_eq("rnd_src_readback", v, s);
      reg_rd(R_CTRL, v, e);  check_eq("rnd_done", {31'b0, v[3]}, 1);
      check_eq("rnd_irq", {31'b0, irq_o}, {31'b0, v[1]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
